// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the execute-stage branch resolver and its compare unit.
package branch_resolve_unit_pkg;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LT  = 3'd2,
        CMP_GE  = 3'd3,
        CMP_LTU = 3'd4,
        CMP_GEU = 3'd5
    } cmp_op_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } bru_state_t;

    localparam logic [1:0] BR_KIND_NONE   = 2'b00;
    localparam logic [1:0] BR_KIND_BRANCH = 2'b01;
    localparam logic [1:0] BR_KIND_JAL    = 2'b10;
    localparam logic [1:0] BR_KIND_JALR   = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Encodings 010/011 are reserved; they map to EQ but the caller flags them illegal.
    function automatic cmp_op_t decode_funct3(input logic [2:0] f3);
        cmp_op_t op;
        case (f3)
            F3_BEQ:  op = CMP_EQ;
            F3_BNE:  op = CMP_NE;
            F3_BLT:  op = CMP_LT;
            F3_BGE:  op = CMP_GE;
            F3_BLTU: op = CMP_LTU;
            F3_BGEU: op = CMP_GEU;
            default: op = CMP_EQ;
        endcase
        return op;
    endfunction

    function automatic logic is_illegal_f3(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// ID/EX issue, result and fetch-redirect signals of the branch resolver.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [1:0]      id_kind;
    logic [2:0]      id_funct3;
    logic [XLEN-1:0] id_rs1;
    logic [XLEN-1:0] id_rs2;
    logic [XLEN-1:0] id_imm;
    logic            id_pred_taken;
    logic [XLEN-1:0] id_pred_target;

    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_link;
    logic            out_illegal;
    logic            out_misalign;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output id_valid, id_pc, id_kind, id_funct3, id_rs1, id_rs2, id_imm,
               id_pred_taken, id_pred_target, out_ready,
        input  id_ready, out_valid, out_taken, out_link, out_illegal, out_misalign,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  id_valid, id_pc, id_kind, id_funct3, id_rs1, id_rs2, id_imm,
               id_pred_taken, id_pred_target, out_ready,
        output id_ready, out_valid, out_taken, out_link, out_illegal, out_misalign,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_resolve_unit_cmpunit.sv
// Combinational comparator evaluating one cmp_op_t on two operands.
module cmpunit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  cmp_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            result
);

    always_comb begin
        result = 1'b0;
        case (op)
            CMP_EQ:  result = (a == b);
            CMP_NE:  result = (a != b);
            CMP_LT:  result = ($signed(a) <  $signed(b));
            CMP_GE:  result = ($signed(a) >= $signed(b));
            CMP_LTU: result = (a <  b);
            CMP_GEU: result = (a >= b);
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: E1 evaluates direction/target, E2 presents the result
// and launches a one-cycle fetch redirect on a mispredict, then flushes for FLUSH_CYCLES.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_unit_if.slave bus,
    input  logic                 stats_clr,
    output logic [CNT_W-1:0]     n_branches,
    output logic [CNT_W-1:0]     n_mispred
);

    localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] LSB_CLR = ~XLEN'(1);

    bru_state_t       state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic             e1_valid_q, e1_valid_d;
    logic [XLEN-1:0]  e1_pc_q, e1_pc_d;
    logic [1:0]       e1_kind_q, e1_kind_d;
    logic [2:0]       e1_funct3_q, e1_funct3_d;
    logic [XLEN-1:0]  e1_rs1_q, e1_rs1_d;
    logic [XLEN-1:0]  e1_rs2_q, e1_rs2_d;
    logic [XLEN-1:0]  e1_imm_q, e1_imm_d;
    logic             e1_pred_taken_q, e1_pred_taken_d;
    logic [XLEN-1:0]  e1_pred_target_q, e1_pred_target_d;

    logic             out_valid_q, out_valid_d;
    logic             out_taken_q, out_taken_d;
    logic [XLEN-1:0]  out_link_q, out_link_d;
    logic             out_illegal_q, out_illegal_d;
    logic             out_misalign_q, out_misalign_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;

    logic [CNT_W-1:0] n_branches_q, n_branches_d;
    logic [CNT_W-1:0] n_mispred_q, n_mispred_d;

    cmp_op_t          e1_op;
    logic             cmp_res;
    logic             e1_taken, e1_illegal, e1_misalign, e1_mispred;
    logic [XLEN-1:0]  e1_target, e1_link, e1_redirect_pc;
    logic             adv2, e2_load, fire, accept, id_ready;

    assign e1_op = decode_funct3(e1_funct3_q);

    cmpunit #(.XLEN(XLEN)) u_cmpunit (
        .op     (e1_op),
        .a      (e1_rs1_q),
        .b      (e1_rs2_q),
        .result (cmp_res)
    );

    always_comb begin
        e1_illegal = 1'b0;
        e1_taken   = 1'b0;
        e1_link    = e1_pc_q + PC_STEP;
        e1_target  = e1_pc_q + e1_imm_q;
        case (e1_kind_q)
            BR_KIND_BRANCH: begin
                e1_illegal = is_illegal_f3(e1_funct3_q);
                e1_taken   = cmp_res && !e1_illegal;
            end
            BR_KIND_JAL: e1_taken = 1'b1;
            BR_KIND_JALR: begin
                e1_taken  = 1'b1;
                e1_target = (e1_rs1_q + e1_imm_q) & LSB_CLR;
            end
            default: e1_taken = 1'b0;
        endcase
        e1_misalign    = e1_taken && e1_target[1];
        // Faulting entries trap later; redirecting on them would only waste a fetch.
        e1_mispred     = !e1_illegal && !e1_misalign &&
                         ((e1_taken != e1_pred_taken_q) ||
                          (e1_taken && (e1_target != e1_pred_target_q)));
        e1_redirect_pc = e1_taken ? e1_target : e1_link;
    end

    assign adv2    = !out_valid_q || bus.out_ready;
    assign e2_load = e1_valid_q && adv2;
    assign fire    = e2_load && e1_mispred;
    assign accept  = bus.id_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (fire) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FC_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        id_ready = (state_q == ST_RUN) && (!e1_valid_q || adv2);
    end

    always_comb begin
        e1_valid_d       = e1_valid_q;
        e1_pc_d          = e1_pc_q;
        e1_kind_d        = e1_kind_q;
        e1_funct3_d      = e1_funct3_q;
        e1_rs1_d         = e1_rs1_q;
        e1_rs2_d         = e1_rs2_q;
        e1_imm_d         = e1_imm_q;
        e1_pred_taken_d  = e1_pred_taken_q;
        e1_pred_target_d = e1_pred_target_q;
        if (accept) begin
            e1_valid_d       = 1'b1;
            e1_pc_d          = bus.id_pc;
            e1_kind_d        = bus.id_kind;
            e1_funct3_d      = bus.id_funct3;
            e1_rs1_d         = bus.id_rs1;
            e1_rs2_d         = bus.id_rs2;
            e1_imm_d         = bus.id_imm;
            e1_pred_taken_d  = bus.id_pred_taken;
            e1_pred_target_d = bus.id_pred_target;
        end else if (adv2) begin
            e1_valid_d = 1'b0;
        end
        // Whatever enters E1 alongside a mispredict is on the wrong path.
        if (fire) begin
            e1_valid_d = 1'b0;
        end

        out_valid_d      = out_valid_q;
        out_taken_d      = out_taken_q;
        out_link_d       = out_link_q;
        out_illegal_d    = out_illegal_q;
        out_misalign_d   = out_misalign_q;
        redirect_valid_d = fire;
        redirect_pc_d    = fire ? e1_redirect_pc : redirect_pc_q;
        if (adv2) begin
            out_valid_d = e1_valid_q;
            if (e1_valid_q) begin
                out_taken_d    = e1_taken;
                out_link_d     = e1_link;
                out_illegal_d  = e1_illegal;
                out_misalign_d = e1_misalign;
            end
        end

        n_branches_d = n_branches_q;
        n_mispred_d  = n_mispred_q;
        if (stats_clr) begin
            n_branches_d = '0;
            n_mispred_d  = '0;
        end else begin
            if (e2_load && (e1_kind_q != BR_KIND_NONE) && (n_branches_q != '1)) begin
                n_branches_d = n_branches_q + CNT_W'(1);
            end
            if (fire && (n_mispred_q != '1)) begin
                n_mispred_d = n_mispred_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_valid_q       <= 1'b0;
            e1_pc_q          <= '0;
            e1_kind_q        <= BR_KIND_NONE;
            e1_funct3_q      <= '0;
            e1_rs1_q         <= '0;
            e1_rs2_q         <= '0;
            e1_imm_q         <= '0;
            e1_pred_taken_q  <= 1'b0;
            e1_pred_target_q <= '0;
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_link_q       <= '0;
            out_illegal_q    <= 1'b0;
            out_misalign_q   <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            n_branches_q     <= '0;
            n_mispred_q      <= '0;
        end else begin
            e1_valid_q       <= e1_valid_d;
            e1_pc_q          <= e1_pc_d;
            e1_kind_q        <= e1_kind_d;
            e1_funct3_q      <= e1_funct3_d;
            e1_rs1_q         <= e1_rs1_d;
            e1_rs2_q         <= e1_rs2_d;
            e1_imm_q         <= e1_imm_d;
            e1_pred_taken_q  <= e1_pred_taken_d;
            e1_pred_target_q <= e1_pred_target_d;
            out_valid_q      <= out_valid_d;
            out_taken_q      <= out_taken_d;
            out_link_q       <= out_link_d;
            out_illegal_q    <= out_illegal_d;
            out_misalign_q   <= out_misalign_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            n_branches_q     <= n_branches_d;
            n_mispred_q      <= n_mispred_d;
        end
    end

    assign bus.id_ready       = id_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_taken      = out_taken_q;
    assign bus.out_link       = out_link_q;
    assign bus.out_illegal    = out_illegal_q;
    assign bus.out_misalign   = out_misalign_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign n_branches         = n_branches_q;
    assign n_mispred          = n_mispred_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised bench for branch_resolve_unit: transaction-level scoreboard checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int XLEN         = 32;
    localparam int FLUSH_CYCLES = 2;
    // Narrow counters so saturation is reachable in a short run.
    localparam int CNT_W        = 8;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        pt;
        logic [31:0] ptgt;
    } instr_t;

    typedef struct {
        instr_t      ins;
        logic        taken;
        logic        illegal;
        logic        misalign;
        logic        mispred;
        logic [31:0] target;
        logic [31:0] link;
        logic [31:0] rpc;
        int          ready_cycle;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             stats_clr = 1'b0;
    logic [CNT_W-1:0] n_branches;
    logic [CNT_W-1:0] n_mispred;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    int          cyc = 0;
    int          flush_end = -1;
    bit          head_shown = 1'b0;
    bit          clr_applied = 1'b0;
    int          m_br = 0;
    int          m_mis = 0;
    int          delivered = 0;
    int          redirects = 0;
    logic [31:0] last_rpc = '0;
    int          ready_mode = 0;

    branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

    branch_resolve_unit #(
        .XLEN         (XLEN),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .stats_clr  (stats_clr),
        .n_branches (n_branches),
        .n_mispred  (n_mispred)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic instr_t mk(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                                  input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                                  input logic pt, input logic [31:0] ptgt);
        instr_t i;
        i.kind = kind; i.f3 = f3; i.pc = pc; i.rs1 = rs1; i.rs2 = rs2;
        i.imm = imm; i.pt = pt; i.ptgt = ptgt;
        return i;
    endfunction

    function automatic exp_t resolve(input instr_t i);
        exp_t e;
        e.ins = i;
        e.illegal = 1'b0;
        e.taken = 1'b0;
        e.link = i.pc + 32'd4;
        e.target = i.pc + i.imm;
        e.ready_cycle = 0;
        case (i.kind)
            2'b01: begin
                case (i.f3)
                    3'b000: e.taken = (i.rs1 == i.rs2);
                    3'b001: e.taken = (i.rs1 != i.rs2);
                    3'b100: e.taken = ($signed(i.rs1) <  $signed(i.rs2));
                    3'b101: e.taken = ($signed(i.rs1) >= $signed(i.rs2));
                    3'b110: e.taken = (i.rs1 <  i.rs2);
                    3'b111: e.taken = (i.rs1 >= i.rs2);
                    default: e.illegal = 1'b1;
                endcase
            end
            2'b10: e.taken = 1'b1;
            2'b11: begin
                e.taken = 1'b1;
                e.target = (i.rs1 + i.imm) & 32'hFFFF_FFFE;
            end
            default: e.taken = 1'b0;
        endcase
        e.misalign = e.taken && e.target[1];
        e.mispred = !e.illegal && !e.misalign &&
                    ((e.taken != i.pt) || (e.taken && (e.target != i.ptgt)));
        e.rpc = e.taken ? e.target : e.link;
        return e;
    endfunction

    // Scoreboard: entries leave in order; a mispredict kills everything younger still in flight.
    always @(negedge clk) begin
        logic exp_out;
        logic exp_redir;
        logic exp_ready;
        cyc++;
        if (!rst_n) begin
            checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
            checkOutput("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
            checkOutput("rst_n_branches", 32'(n_branches), 32'd0);
            checkOutput("rst_n_mispred", 32'(n_mispred), 32'd0);
            sb.delete();
            head_shown = 1'b0;
            flush_end = -1;
            clr_applied = 1'b0;
            m_br = 0;
            m_mis = 0;
        end else begin
            if (clr_applied) begin
                m_br = 0;
                m_mis = 0;
            end
            exp_out = (sb.size() > 0) && (sb[0].ready_cycle <= cyc);
            exp_redir = 1'b0;
            if (exp_out && !head_shown) begin
                head_shown = 1'b1;
                if (!clr_applied) begin
                    if (sb[0].ins.kind != 2'b00 && m_br < CNT_MAX) m_br++;
                    if (sb[0].mispred && m_mis < CNT_MAX) m_mis++;
                end
                if (sb[0].mispred) begin
                    exp_redir = 1'b1;
                    while (sb.size() > 1) void'(sb.pop_back());
                    flush_end = cyc + FLUSH_CYCLES - 1;
                end
            end
            checkOutput("out_valid", 32'(bus.out_valid), 32'(exp_out));
            if (exp_out) begin
                checkOutput("out_taken", 32'(bus.out_taken), 32'(sb[0].taken));
                checkOutput("out_link", bus.out_link, sb[0].link);
                checkOutput("out_illegal", 32'(bus.out_illegal), 32'(sb[0].illegal));
                checkOutput("out_misalign", 32'(bus.out_misalign), 32'(sb[0].misalign));
            end
            checkOutput("redirect_valid", 32'(bus.redirect_valid), 32'(exp_redir));
            if (exp_redir) checkOutput("redirect_pc", bus.redirect_pc, sb[0].rpc);
            if (cyc <= flush_end) exp_ready = 1'b0;
            else if (exp_out && sb.size() >= 2) exp_ready = bus.out_ready;
            else exp_ready = 1'b1;
            checkOutput("id_ready", 32'(bus.id_ready), 32'(exp_ready));
            checkOutput("n_branches", 32'(n_branches), 32'(m_br));
            checkOutput("n_mispred", 32'(n_mispred), 32'(m_mis));

            if (bus.redirect_valid) begin
                redirects++;
                last_rpc = bus.redirect_pc;
            end
            if (bus.out_valid && bus.out_ready) delivered++;
            if (exp_out && bus.out_ready) begin
                void'(sb.pop_front());
                head_shown = 1'b0;
            end
            if (bus.id_valid && bus.id_ready) begin
                exp_t e;
                e = resolve(mk(bus.id_kind, bus.id_funct3, bus.id_pc, bus.id_rs1, bus.id_rs2,
                               bus.id_imm, bus.id_pred_taken, bus.id_pred_target));
                e.ready_cycle = cyc + 2;
                sb.push_back(e);
            end
            clr_applied = stats_clr;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    task automatic applyStimulus(input instr_t i);
        bit got;
        bus.id_pc = i.pc;
        bus.id_kind = i.kind;
        bus.id_funct3 = i.f3;
        bus.id_rs1 = i.rs1;
        bus.id_rs2 = i.rs2;
        bus.id_imm = i.imm;
        bus.id_pred_taken = i.pt;
        bus.id_pred_target = i.ptgt;
        bus.id_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (rst_n && bus.id_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: got no acceptance, expected id_ready within 200 cycles");
        end
    endtask

    task automatic idleCycles(input int n);
        bus.id_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic instr_t randomInstr();
        instr_t i;
        exp_t e;
        logic [31:0] pool[5];
        pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'h7FFF_FFFF;
        pool[3] = 32'h8000_0000; pool[4] = 32'hFFFF_FFFF;
        i.kind = 2'($urandom_range(0, 3));
        i.f3 = 3'($urandom_range(0, 7));
        i.pc = $urandom & 32'hFFFF_FFFC;
        i.rs1 = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 4)] : $urandom;
        i.rs2 = ($urandom_range(0, 2) == 0) ? i.rs1 :
                (($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 4)] : $urandom);
        i.imm = 32'($urandom_range(0, 127)) * 32'd2 - 32'd128;
        if ($urandom_range(0, 7) == 0) i.imm = i.imm + 32'd1;
        e = resolve(i);
        if ($urandom_range(0, 1) != 0) begin
            i.pt = e.taken;
            i.ptgt = e.target;
        end else begin
            i.pt = 1'($urandom_range(0, 1));
            i.ptgt = ($urandom_range(0, 1) != 0) ? e.target : e.target + 32'd4;
        end
        return i;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before 50000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        instr_t i;
        exp_t e;
        int d0;
        int r0;
        int got;
        bus.id_valid = 1'b0;
        bus.id_pc = '0; bus.id_kind = '0; bus.id_funct3 = '0;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_imm = '0;
        bus.id_pred_taken = 1'b0; bus.id_pred_target = '0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset_id_ready", 32'(bus.id_ready), 32'd1);

        i = mk(2'b01, 3'b000, 32'h100, 32'h1234_5678, 32'h1234_5678, 32'h20, 1'b1, 32'h120);
        e = resolve(i);
        checkOutput("t1_model_taken", 32'(e.taken), 32'd1);
        checkOutput("t1_model_mispred", 32'(e.mispred), 32'd0);
        d0 = delivered; r0 = redirects;
        applyStimulus(i);
        idleCycles(4);
        checkOutput("t1_delivered", 32'(delivered - d0), 32'd1);
        checkOutput("t1_no_redirect", 32'(redirects - r0), 32'd0);

        i = mk(2'b01, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        e = resolve(i);
        checkOutput("t2_model_rpc", e.rpc, 32'h1F8);
        r0 = redirects;
        applyStimulus(i);
        idleCycles(5);
        checkOutput("t2_redirects", 32'(redirects - r0), 32'd1);
        checkOutput("t2_redirect_pc", last_rpc, 32'h1F8);
        checkOutput("t2_n_mispred", 32'(n_mispred), 32'd1);

        i = mk(2'b01, 3'b111, 32'h300, 32'h7FFF_FFFF, 32'h8000_0000, 32'h40, 1'b1, 32'h340);
        d0 = delivered; r0 = redirects;
        applyStimulus(i);
        applyStimulus(mk(2'b00, 3'b000, 32'h304, 32'h5, 32'h6, 32'h0, 1'b0, 32'h0));
        idleCycles(5);
        checkOutput("t3_redirect_pc", last_rpc, 32'h304);
        checkOutput("t3_delivered", 32'(delivered - d0), 32'd1);

        i = mk(2'b11, 3'b000, 32'h400, 32'h1003, 32'h0, 32'h0, 1'b1, 32'h1002);
        e = resolve(i);
        checkOutput("t4_model_target", e.target, 32'h1002);
        checkOutput("t4_model_link", e.link, 32'h404);
        r0 = redirects;
        applyStimulus(i);
        i = mk(2'b11, 3'b000, 32'h404, 32'h1006, 32'h0, 32'h0, 1'b1, 32'h0);
        e = resolve(i);
        checkOutput("t4_model_misalign", 32'(e.misalign), 32'd1);
        applyStimulus(i);
        idleCycles(4);
        checkOutput("t4_no_redirect", 32'(redirects - r0), 32'd0);

        d0 = delivered;
        ready_mode = 2;
        fork
            begin
                applyStimulus(mk(2'b10, 3'b000, 32'h600, 32'h0, 32'h0, 32'h10, 1'b1, 32'h610));
                applyStimulus(mk(2'b00, 3'b000, 32'h604, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0));
                applyStimulus(mk(2'b01, 3'b001, 32'h608, 32'h3, 32'h4, 32'h8, 1'b1, 32'h610));
                idleCycles(1);
            end
            begin
                repeat (5) @(posedge clk);
                #1 ready_mode = 0;
            end
        join
        idleCycles(4);
        checkOutput("t5_delivered", 32'(delivered - d0), 32'd3);

        i = mk(2'b01, 3'b010, 32'h500, 32'h1, 32'h1, 32'h10, 1'b0, 32'h0);
        e = resolve(i);
        checkOutput("t6_model_illegal", 32'(e.illegal), 32'd1);
        r0 = redirects;
        applyStimulus(i);
        idleCycles(4);
        checkOutput("t6_no_redirect", 32'(redirects - r0), 32'd0);

        for (int k = 0; k < CNT_MAX + 5; k++) begin
            applyStimulus(mk(2'b10, 3'b000, 32'h0, 32'h0, 32'h0, 32'h4, 1'b1, 32'h4));
        end
        idleCycles(4);
        checkOutput("sat_n_branches", 32'(n_branches), 32'(CNT_MAX));

        stats_clr = 1'b1;
        idleCycles(1);
        stats_clr = 1'b0;
        idleCycles(1);
        checkOutput("clr_n_branches", 32'(n_branches), 32'd0);

        r0 = redirects;
        applyStimulus(mk(2'b01, 3'b001, 32'h700, 32'h1, 32'h2, 32'h10, 1'b0, 32'h0));
        bus.id_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            @(negedge clk);
            if (bus.redirect_valid) got = 1;
        end
        checkOutput("rst_flush_redirect_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_flush_redirect_low", 32'(bus.redirect_valid), 32'd0);
        idleCycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_flush_id_ready", 32'(bus.id_ready), 32'd1);
        @(posedge clk);
        #1;

        ready_mode = 1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 40) == 0) stats_clr = 1'b1;
            applyStimulus(randomInstr());
            stats_clr = 1'b0;
            if ($urandom_range(0, 5) == 0) idleCycles($urandom_range(1, 3));
        end
        ready_mode = 0;
        idleCycles(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
